// File: rtl/ccip_flow_batch_transmitter.sv
// ccip_flow_batch_transmitter
// Per-flow line FIFOs feeding a round-robin batch scheduler that writes each
// full batch to host memory as one multi-line eREQ_WRLINE_I burst on CCI-P
// channel 1.
// Optional build macro CCIP_TX_FLUSH_TIMEOUT_EN: adds per-flow age counters
// that flush a partial batch as single-line writes after FLUSH_TIMEOUT cycles.
//
// state  | meaning
// -------+-------------------------------------------------------------------
// IDLE   | scan pointer walks flows 0..number_of_flows looking for a ready flow
// BURST  | pop one line per cycle from the latched flow; output is registered

package ccip_if_pkg;
    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;
endpackage

module ccip_flow_batch_transmitter
    import ccip_if_pkg::*;
#(
    parameter int NIC_ID      = 0,
    parameter int LNUM_FLOWS  = 2,
    parameter int LFIFO_DEPTH = 3,
    parameter int LMAX_BATCH  = 2,
    parameter int RPC_WIDTH   = 512
`ifdef CCIP_TX_FLUSH_TIMEOUT_EN
    , parameter int FLUSH_TIMEOUT = 64
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LNUM_FLOWS-1:0] number_of_flows,
    input  logic [41:0]           tx_base_addr,
    input  logic [1:0]            l_batch_size,
    input  logic                  in_valid,
    input  logic [RPC_WIDTH-1:0]  in_data,
    input  logic [LNUM_FLOWS-1:0] in_flow_id,
    output logic                  in_ready,
    input  logic                  sRx_c1TxAlmFull,
    output t_if_ccip_c1_Tx        sTx_c1,
    output logic [31:0]           lines_sent,
    output logic                  error
);
    localparam int NUM_FLOWS = 2 ** LNUM_FLOWS;
    localparam int DEPTH     = 2 ** LFIFO_DEPTH;
    localparam int IDX_W     = (LMAX_BATCH > 0) ? LMAX_BATCH : 1;
    localparam logic [1:0]           LMAX_LB  = 2'(LMAX_BATCH);
    localparam logic [LFIFO_DEPTH:0] OCC_FULL = (LFIFO_DEPTH + 1)'(DEPTH);

    typedef enum logic {S_IDLE, S_BURST} t_state;

    t_state                r_state, w_state_next;
    logic [LNUM_FLOWS-1:0] r_ptr, w_ptr_next;
    logic [LNUM_FLOWS-1:0] r_flow, w_flow_next;
    logic [1:0]            r_lb, w_lb_next;
    logic [IDX_W-1:0]      r_idx, w_idx_next;
    logic [IDX_W-1:0]      r_last, w_last_next;
    logic                  r_single, w_single_next;

    logic [RPC_WIDTH-1:0]   r_mem [NUM_FLOWS][DEPTH];
    logic [LFIFO_DEPTH-1:0] r_wr_ptr [NUM_FLOWS];
    logic [LFIFO_DEPTH-1:0] r_rd_ptr [NUM_FLOWS];
    logic [LFIFO_DEPTH:0]   r_occ [NUM_FLOWS];

    logic                  w_push, w_pop, w_error_set;
    logic [NUM_FLOWS-1:0]  w_push_vec, w_pop_vec;
    logic [1:0]            w_lb_eff;
    logic                  w_lb_bad;
    logic [LFIFO_DEPTH:0]  w_batch, w_occ_ptr;
    logic                  w_batch_ready, w_flush_ready;
    logic [IDX_W-1:0]      w_batch_last, w_flush_last;
    logic [LNUM_FLOWS-1:0] w_ptr_adv, w_flow_adv;

    logic                  r_tx_valid;
    t_ccip_c1_ReqMemHdr    r_tx_hdr, w_hdr;
    logic [511:0]          r_tx_data, w_data_ext;
    logic [31:0]           r_lines_sent;
    logic                  r_error;

    assign in_ready = start && (r_occ[in_flow_id] != OCC_FULL);
    assign w_push   = in_valid && in_ready;

    // Out-of-range batch sizes are clamped to the largest supported batch.
    assign w_lb_bad      = l_batch_size > LMAX_LB;
    assign w_lb_eff      = w_lb_bad ? LMAX_LB : l_batch_size;
    assign w_batch       = {{LFIFO_DEPTH{1'b0}}, 1'b1} << w_lb_eff;
    assign w_batch_last  = IDX_W'((32'd1 << w_lb_eff) - 32'd1);
    assign w_occ_ptr     = r_occ[r_ptr];
    assign w_batch_ready = w_occ_ptr >= w_batch;

    // Scan wraps after the last active flow; an out-of-range pointer also wraps.
    assign w_ptr_adv  = (r_ptr  >= number_of_flows) ? '0 : r_ptr  + 1'b1;
    assign w_flow_adv = (r_flow >= number_of_flows) ? '0 : r_flow + 1'b1;

`ifdef CCIP_TX_FLUSH_TIMEOUT_EN
    localparam int AGE_W = $clog2(FLUSH_TIMEOUT + 1);
    logic [AGE_W-1:0] r_age [NUM_FLOWS];

    // Age a partial batch; the flow being drained has its age held at zero.
    always_ff @(posedge clk) begin
        for (int f = 0; f < NUM_FLOWS; f++) begin
            if (reset) begin
                r_age[f] <= '0;
            end else if ((r_state == S_BURST && r_flow == LNUM_FLOWS'(f)) ||
                         r_occ[f] == '0 || r_occ[f] >= w_batch) begin
                r_age[f] <= '0;
            end else if (r_age[f] != AGE_W'(FLUSH_TIMEOUT)) begin
                r_age[f] <= r_age[f] + 1'b1;
            end
        end
    end

    assign w_flush_ready = (r_age[r_ptr] == AGE_W'(FLUSH_TIMEOUT)) && (w_occ_ptr != '0);
    assign w_flush_last  = IDX_W'(w_occ_ptr - 1'b1);
`else
    assign w_flush_ready = 1'b0;
    assign w_flush_last  = '0;
`endif

    // FSM state and burst context registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_flow   <= '0;
            r_lb     <= '0;
            r_idx    <= '0;
            r_last   <= '0;
            r_single <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ptr    <= w_ptr_next;
            r_flow   <= w_flow_next;
            r_lb     <= w_lb_next;
            r_idx    <= w_idx_next;
            r_last   <= w_last_next;
            r_single <= w_single_next;
        end
    end

    // Next-state: burst decision in IDLE, one pop per cycle in BURST.
    always_comb begin
        w_state_next  = r_state;
        w_ptr_next    = r_ptr;
        w_flow_next   = r_flow;
        w_lb_next     = r_lb;
        w_idx_next    = r_idx;
        w_last_next   = r_last;
        w_single_next = r_single;
        w_pop         = 1'b0;
        w_error_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !sRx_c1TxAlmFull && (w_batch_ready || w_flush_ready)) begin
                    w_state_next  = S_BURST;
                    w_flow_next   = r_ptr;
                    w_lb_next     = w_lb_eff;
                    w_idx_next    = '0;
                    w_single_next = !w_batch_ready;
                    w_last_next   = w_batch_ready ? w_batch_last : w_flush_last;
                    w_error_set   = w_lb_bad;
                end else begin
                    w_ptr_next = w_ptr_adv;
                end
            end
            S_BURST: begin
                w_pop = 1'b1;
                if (r_idx == r_last) begin
                    w_state_next = S_IDLE;
                    w_ptr_next   = w_flow_adv;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One-hot per-flow push/pop strobes.
    always_comb begin
        w_push_vec = '0;
        w_pop_vec  = '0;
        if (w_push) w_push_vec[in_flow_id] = 1'b1;
        if (w_pop)  w_pop_vec[r_flow]      = 1'b1;
    end

    // FIFO storage; contents are don't-care until counted by occupancy.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[in_flow_id][r_wr_ptr[in_flow_id]] <= in_data;
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel.
    always_ff @(posedge clk) begin
        for (int f = 0; f < NUM_FLOWS; f++) begin
            if (reset) begin
                r_wr_ptr[f] <= '0;
                r_rd_ptr[f] <= '0;
                r_occ[f]    <= '0;
            end else begin
                if (w_push_vec[f]) r_wr_ptr[f] <= r_wr_ptr[f] + 1'b1;
                if (w_pop_vec[f])  r_rd_ptr[f] <= r_rd_ptr[f] + 1'b1;
                case ({w_push_vec[f], w_pop_vec[f]})
                    2'b10:   r_occ[f] <= r_occ[f] + 1'b1;
                    2'b01:   r_occ[f] <= r_occ[f] - 1'b1;
                    default: r_occ[f] <= r_occ[f];
                endcase
            end
        end
    end

    // Header and zero-extended payload for the line popped this cycle.
    always_comb begin
        w_hdr          = '0;
        w_hdr.req_type = eREQ_WRLINE_I;
        w_hdr.vc_sel   = eVC_VH0;
        w_hdr.sop      = r_single || (r_idx == '0);
        w_hdr.address  = tx_base_addr + (42'(r_flow) << r_lb) + 42'(r_idx);
        w_hdr.mdata    = 16'(NIC_ID);
        if (r_single) begin
            w_hdr.cl_len = eCL_LEN_1;
        end else begin
            case (r_lb)
                2'd0:    w_hdr.cl_len = eCL_LEN_1;
                2'd1:    w_hdr.cl_len = eCL_LEN_2;
                default: w_hdr.cl_len = eCL_LEN_4;
            endcase
        end
        w_data_ext                  = '0;
        w_data_ext[RPC_WIDTH-1:0]   = r_mem[r_flow][r_rd_ptr[r_flow]];
    end

    // Channel-1 output register: one cycle from pop to valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_valid <= 1'b0;
            r_tx_hdr   <= '0;
            r_tx_data  <= '0;
        end else begin
            r_tx_valid <= w_pop;
            if (w_pop) begin
                r_tx_hdr  <= w_hdr;
                r_tx_data <= w_data_ext;
            end
        end
    end

    // Issued-line counter and sticky configuration error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lines_sent <= '0;
            r_error      <= 1'b0;
        end else begin
            r_lines_sent <= r_lines_sent + {31'd0, r_tx_valid};
            if (w_error_set) r_error <= 1'b1;
        end
    end

    assign sTx_c1     = {r_tx_hdr, r_tx_data, r_tx_valid};
    assign lines_sent = r_lines_sent;
    assign error      = r_error;

endmodule

// File: tb/tb_ccip_flow_batch_transmitter.sv
// Scoreboard bench for ccip_flow_batch_transmitter: the model turns every
// completed per-flow batch into expected write records; a monitor matches
// issued lines against them. Build with CCIP_TX_FLUSH_TIMEOUT_EN to exercise
// the flush path instead of the partial-batch hold.
`timescale 1ns/1ps
module tb_ccip_flow_batch_transmitter;
    import ccip_if_pkg::*;

    localparam int LNF = 2;
    localparam int NF  = 4;
    localparam int W   = 512;

    logic           clk = 1'b0;
    logic           reset, start, in_valid, in_ready, alm_full, error;
    logic [LNF-1:0] number_of_flows, in_flow_id;
    logic [41:0]    tx_base_addr;
    logic [1:0]     l_batch_size;
    logic [W-1:0]   in_data;
    logic [31:0]    lines_sent;
    t_if_ccip_c1_Tx sTx_c1;

    always #5 clk = ~clk;

    ccip_flow_batch_transmitter #(
        .NIC_ID(0), .LNUM_FLOWS(LNF), .LFIFO_DEPTH(3), .LMAX_BATCH(2), .RPC_WIDTH(W)
`ifdef CCIP_TX_FLUSH_TIMEOUT_EN
        , .FLUSH_TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .reset(reset), .start(start), .number_of_flows(number_of_flows),
        .tx_base_addr(tx_base_addr), .l_batch_size(l_batch_size), .in_valid(in_valid),
        .in_data(in_data), .in_flow_id(in_flow_id), .in_ready(in_ready),
        .sRx_c1TxAlmFull(alm_full), .sTx_c1(sTx_c1), .lines_sent(lines_sent), .error(error)
    );

    typedef struct {
        logic [41:0]  addr;
        logic [1:0]   cl;
        logic         sop;
        logic [W-1:0] data;
    } rec_t;

    rec_t         exp_q[NF][$];
    logic [W-1:0] pend_q[NF][$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           exp_total = 0;
    int           mdl_lb = 0;
    int           mon_lb = 0;
    int           mon_rem = 0;
    int           burst_order[$];

    function automatic logic [1:0] cl_of(int lb);
        case (lb)
            0:       return eCL_LEN_1;
            1:       return eCL_LEN_2;
            default: return eCL_LEN_4;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_line();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Accepted line: once a flow holds a whole batch it becomes one burst at
    // base + flow*B + i.
    function automatic void model_accept(int f, logic [W-1:0] d);
        int b;
        b = 1 << mdl_lb;
        pend_q[f].push_back(d);
        if (pend_q[f].size() == b) begin
            for (int i = 0; i < b; i++) begin
                rec_t r;
                r.addr = tx_base_addr + 42'(f * b + i);
                r.cl   = cl_of(mdl_lb);
                r.sop  = (i == 0);
                r.data = pend_q[f][i];
                exp_q[f].push_back(r);
            end
            pend_q[f].delete();
            exp_total += b;
        end
    endfunction

    // A timed-out partial batch leaves as independent single-line writes.
    function automatic void model_flush(int f);
        int b;
        b = 1 << mdl_lb;
        for (int i = 0; i < pend_q[f].size(); i++) begin
            rec_t r;
            r.addr = tx_base_addr + 42'(f * b + i);
            r.cl   = eCL_LEN_1;
            r.sop  = 1'b1;
            r.data = pend_q[f][i];
            exp_q[f].push_back(r);
        end
        exp_total += pend_q[f].size();
        pend_q[f].delete();
    endfunction

    function automatic bit all_empty();
        for (int f = 0; f < NF; f++) if (exp_q[f].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(int f, logic [W-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_flow_id = LNF'(f);
        in_data    = d;
        #1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: flow %0d in_ready=0 expected 1", f);
        end else begin
            @(posedge clk);
            model_accept(f, d);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(string name);
        int n;
        n = 0;
        while (!all_empty() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        check({name, "_drained"}, 64'(all_empty()), 64'd1);
        check({name, "_lines_sent"}, 64'(lines_sent), 64'(exp_total));
    endtask

    task automatic wait_first_valid(string name);
        int n;
        n = 0;
        while (!sTx_c1.valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_burst_started"}, 64'(sTx_c1.valid), 64'd1);
    endtask

    // Monitor: match each issued line to the next record of its flow and
    // require multi-line bursts to be gap-free.
    always @(negedge clk) begin
        logic [41:0] off;
        rec_t        r;
        int          f;
        if (reset) begin
            mon_rem = 0;
        end else if (sTx_c1.valid) begin
            off = (sTx_c1.hdr.address - tx_base_addr) >> mon_lb;
            n_checks++;
            if (off >= 42'(NF)) begin
                n_fail++;
                mon_rem = 0;
                $display("FAIL unexpected_write: addr=%0h outside any flow slot", sTx_c1.hdr.address);
            end else if (exp_q[int'(off)].size() == 0) begin
                n_fail++;
                mon_rem = 0;
                $display("FAIL unexpected_write: addr=%0h no write expected for flow %0d",
                         sTx_c1.hdr.address, int'(off));
            end else begin
                f = int'(off);
                r = exp_q[f].pop_front();
                if (sTx_c1.hdr.address !== r.addr || sTx_c1.hdr.cl_len !== r.cl ||
                    sTx_c1.hdr.sop !== r.sop || sTx_c1.hdr.req_type !== eREQ_WRLINE_I ||
                    sTx_c1.hdr.vc_sel !== eVC_VH0 || sTx_c1.data[W-1:0] !== r.data) begin
                    n_fail++;
                    $display("FAIL write_line: actual addr=%0h cl=%0d sop=%0d type=%0d vc=%0d data[31:0]=%0h expected addr=%0h cl=%0d sop=%0d type=0 vc=2 data[31:0]=%0h",
                             sTx_c1.hdr.address, sTx_c1.hdr.cl_len, sTx_c1.hdr.sop,
                             sTx_c1.hdr.req_type, sTx_c1.hdr.vc_sel, sTx_c1.data[31:0],
                             r.addr, r.cl, r.sop, r.data[31:0]);
                end
                if (r.sop) begin
                    mon_rem = (r.cl == eCL_LEN_4) ? 3 : (r.cl == eCL_LEN_2) ? 1 : 0;
                    burst_order.push_back(f);
                end else if (mon_rem > 0) begin
                    mon_rem--;
                end
            end
        end else if (mon_rem > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL burst_gap: valid=0 with %0d burst lines outstanding", mon_rem);
            mon_rem = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int prior;
        reset           = 1'b1;
        start           = 1'b0;
        alm_full        = 1'b0;
        in_valid        = 1'b0;
        in_data         = '0;
        in_flow_id      = '0;
        number_of_flows = '0;
        tx_base_addr    = 42'h100;
        l_batch_size    = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(sTx_c1.valid), 64'd0);
        check("rst_hdr_zero", 64'(sTx_c1.hdr == '0), 64'd1);
        check("rst_lines_sent", 64'(lines_sent), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_in_ready_no_start", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        #1;
        check("in_ready_after_start", 64'(in_ready), 64'd1);

        // single-line batches on one flow
        number_of_flows = 2'd0; l_batch_size = 2'd0; mdl_lb = 0; mon_lb = 0;
        for (int i = 0; i < 3; i++) push(0, rnd_line());
        wait_drain("lb0_three_lines");

        // 4-line burst from flow 2
        number_of_flows = 2'd3; l_batch_size = 2'd2; mdl_lb = 2; mon_lb = 2;
        for (int i = 0; i < 4; i++) push(2, rnd_line());
        wait_drain("lb2_flow2_burst");

        // round-robin between two preloaded flows
        number_of_flows = 2'd1; l_batch_size = 2'd1; mdl_lb = 1; mon_lb = 1;
        alm_full = 1'b1;
        for (int i = 0; i < 4; i++) push(0, rnd_line());
        for (int i = 0; i < 4; i++) push(1, rnd_line());
        burst_order.delete();
        @(negedge clk);
        alm_full = 1'b0;
        wait_drain("rr_two_flows");
        check("rr_burst_count", 64'(burst_order.size()), 64'd4);
        for (int i = 1; i < burst_order.size(); i++)
            check("rr_alternates", 64'(burst_order[i] != burst_order[i-1]), 64'd1);

        // full FIFO under almost-full, then drain
        number_of_flows = 2'd3; l_batch_size = 2'd2; mdl_lb = 2; mon_lb = 2;
        alm_full = 1'b1;
        prior = exp_total;
        for (int i = 0; i < 8; i++) push(3, rnd_line());
        @(negedge clk);
        in_valid = 1'b1; in_flow_id = 2'd3; in_data = rnd_line();
        #1;
        check("full_in_ready", 64'(in_ready), 64'd0);
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        check("almfull_no_write", 64'(lines_sent), 64'(prior));
        alm_full = 1'b0;
        wait_drain("full_drain");

        // batch size change during a burst affects only later bursts
        number_of_flows = 2'd0; l_batch_size = 2'd2; mdl_lb = 2; mon_lb = 2;
        alm_full = 1'b1;
        for (int i = 0; i < 4; i++) push(0, rnd_line());
        @(negedge clk);
        alm_full = 1'b0;
        wait_first_valid("lbchg");
        l_batch_size = 2'd0; mdl_lb = 0;
        for (int i = 0; i < 2; i++) push(0, rnd_line());
        wait_drain("lb_change");

        // partial batch: held without flush, flushed with it
        number_of_flows = 2'd3; l_batch_size = 2'd2; mdl_lb = 2; mon_lb = 2;
        for (int i = 0; i < 2; i++) push(1, rnd_line());
`ifdef CCIP_TX_FLUSH_TIMEOUT_EN
        model_flush(1);
        wait_drain("flush_timeout");
`else
        repeat (100) @(negedge clk);
        check("partial_held", 64'(lines_sent), 64'(exp_total));
        for (int i = 0; i < 2; i++) push(1, rnd_line());
        wait_drain("partial_completed");
`endif

        // illegal batch size clamps to 4 lines and sets error
        check("error_clear_before", 64'(error), 64'd0);
        number_of_flows = 2'd0; l_batch_size = 2'd3; mdl_lb = 2; mon_lb = 2;
        for (int i = 0; i < 4; i++) push(0, rnd_line());
        wait_drain("illegal_lb");
        check("error_sticky_set", 64'(error), 64'd1);

`ifndef CCIP_TX_FLUSH_TIMEOUT_EN
        // randomized traffic over all flows and batch sizes
        for (int ph = 0; ph < 3; ph++) begin
            number_of_flows = 2'd3;
            l_batch_size    = 2'(ph);
            mdl_lb = ph; mon_lb = ph;
            tx_base_addr = {$urandom_range(0, 1023), 32'd0} | 42'({$urandom} & 32'hFFFF_FFFC);
            for (int k = 0; k < 30; k++) begin
                alm_full = ($urandom_range(0, 3) == 0);
                push($urandom_range(0, 3), rnd_line());
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            alm_full = 1'b0;
            for (int f = 0; f < NF; f++)
                while (pend_q[f].size() != 0) push(f, rnd_line());
            wait_drain("random_phase");
        end
`endif

        // reset during a burst discards everything
        tx_base_addr = 42'h200;
        number_of_flows = 2'd0; l_batch_size = 2'd2; mdl_lb = 2; mon_lb = 2;
        alm_full = 1'b1;
        for (int i = 0; i < 8; i++) push(0, rnd_line());
        @(negedge clk);
        alm_full = 1'b0;
        wait_first_valid("midreset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_valid", 64'(sTx_c1.valid), 64'd0);
        check("midreset_lines_sent", 64'(lines_sent), 64'd0);
        check("midreset_error", 64'(error), 64'd0);
        for (int f = 0; f < NF; f++) begin
            exp_q[f].delete();
            pend_q[f].delete();
        end
        exp_total = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("after_reset_no_writes", 64'(lines_sent), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
